// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: fetches one- or two-byte instructions over the
// shared 8-bit bus, strobes the PC/MAR/code memory and performs absolute jumps.
module fetch_seq #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mem_ready,
  inout  wire  [7:0] bus,
  output logic       pc_r,
  output logic       pc_i,
  output logic       pc_w,
  output logic       mar_w,
  output logic       mem_rd,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int CW = ($clog2(WAIT_MAX + 1) < 4) ? 4 : $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {IDLE, A1, R1, A2, R2, JMP, DONE, ERR} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          timeout;
  logic          drive;

  // After WAIT_MAX low cycles one more ready cycle is still honoured; a further low one errors out.
  assign timeout = (wait_cnt == CW'(WAIT_MAX)) && !mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      opcode   <= '0;
      operand  <= '0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= A1;
        A1: begin
          wait_cnt <= '0;
          state    <= R1;
        end
        R1: begin
          if (mem_ready) begin
            opcode   <= bus;
            wait_cnt <= '0;
            state    <= bus[7] ? A2 : DONE;
          end else if (timeout) begin
            err   <= 1'b1;
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        A2: begin
          wait_cnt <= '0;
          state    <= R2;
        end
        R2: begin
          if (mem_ready) begin
            operand  <= bus;
            wait_cnt <= '0;
            state    <= opcode[6] ? JMP : DONE;
          end else if (timeout) begin
            err   <= 1'b1;
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        JMP:     state <= DONE;
        DONE:    state <= IDLE;
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are pure state decode, so a single bus driver per state is guaranteed.
  assign pc_r   = (state == A1) || (state == A2);
  assign mar_w  = pc_r;
  assign mem_rd = (state == R1) || (state == R2);
  assign pc_i   = mem_rd && mem_ready;
  assign pc_w   = (state == JMP);
  assign drive  = (state == JMP);
  assign busy   = (state != IDLE) && (state != ERR);
  assign done   = (state == DONE);

  assign bus = drive ? operand : 8'hzz;
endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a small PC / MAR / code-memory environment on the bus.
module tb_fetch_seq;
  logic       clk = 1'b0;
  logic       reset, start, mem_ready;
  wire  [7:0] bus;
  logic       pc_r, pc_i, pc_w, mar_w, mem_rd, busy, done, err;
  logic [7:0] opcode, operand;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  logic [7:0] mem [256];
  logic [7:0] pc, mar, pc_set_val, jbus;
  logic       pc_set;
  logic [5:0] tr [0:63];

  fetch_seq #(.WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready), .bus(bus),
    .pc_r(pc_r), .pc_i(pc_i), .pc_w(pc_w), .mar_w(mar_w), .mem_rd(mem_rd),
    .opcode(opcode), .operand(operand), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Environment: PC and code memory share the bus with the DUT
  assign bus = pc_r ? pc : 8'hzz;
  assign bus = mem_rd ? mem[mar] : 8'hzz;

  always @(posedge clk) begin
    if (pc_set) pc <= pc_set_val;
    else if (pc_w) pc <= bus;
    else if (pc_i) pc <= pc + 8'd1;
    if (mar_w) mar <= bus;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (int'(pc_r) + int'(mem_rd) + int'(dut.drive) > 1) viol++;
      if (pc_i && pc_w) viol++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setpc(input logic [7:0] v);
    pc_set = 1'b1; pc_set_val = v; tick(); pc_set = 1'b0;
  endtask

  // Start one fetch; memory answers after w1 / w2 wait cycles in the first / second read.
  task automatic run_fetch(input int w1, input int w2, output int lat, output int npci, output int npcw);
    int rph, left;
    logic prev_rd;
    rph = 0; left = 0; prev_rd = 1'b0;
    lat = 0; npci = 0; npcw = 0; jbus = 8'h00;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (mem_rd && !prev_rd) begin
        rph++;
        left = (rph == 1) ? w1 : w2;
      end
      prev_rd = mem_rd;
      mem_ready = mem_rd && (left == 0);
      if (mem_rd && left > 0) left--;
      #1;
      tr[c] = {pc_r, mar_w, mem_rd, pc_i, pc_w, done};
      if (pc_i) npci++;
      if (pc_w) begin npcw++; jbus = bus; end
      if (done) begin lat = c; tick(); break; end
      tick();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; pc_set = 1'b0;
    tick(); tick();
    reset = 1'b0;
    total++; if (opcode !== 8'h00) begin bad++; $display("FAIL reset_opcode got=%h exp=00", opcode); end
    total++; if (operand !== 8'h00) begin bad++; $display("FAIL reset_operand got=%h exp=00", operand); end
    total++; if ({err, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {err, busy, done}); end
    total++; if ({pc_r, pc_i, pc_w, mar_w, mem_rd, dut.drive} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=000000", {pc_r, pc_i, pc_w, mar_w, mem_rd, dut.drive}); end
  endtask

  task automatic test_one_byte();
    int lat, npci, npcw;
    mem[8'h10] = 8'h05; setpc(8'h10);
    run_fetch(0, 0, lat, npci, npcw);
    total++; if (lat !== 3) begin bad++; $display("FAIL one_byte_latency got=%0d exp=3", lat); end
    total++; if (tr[1] !== 6'b110000) begin bad++; $display("FAIL one_byte_a1 got=%b exp=110000", tr[1]); end
    total++; if (tr[2] !== 6'b001100) begin bad++; $display("FAIL one_byte_r1 got=%b exp=001100", tr[2]); end
    total++; if (tr[3] !== 6'b000001) begin bad++; $display("FAIL one_byte_done got=%b exp=000001", tr[3]); end
    total++; if (opcode !== 8'h05) begin bad++; $display("FAIL one_byte_opcode got=%h exp=05", opcode); end
    total++; if (operand !== 8'h00) begin bad++; $display("FAIL one_byte_operand got=%h exp=00", operand); end
    total++; if (pc !== 8'h11) begin bad++; $display("FAIL one_byte_pc got=%h exp=11", pc); end
  endtask

  task automatic test_two_byte();
    int lat, npci, npcw;
    mem[8'h20] = 8'h8A; mem[8'h21] = 8'h3C; setpc(8'h20);
    run_fetch(0, 0, lat, npci, npcw);
    total++; if (lat !== 5) begin bad++; $display("FAIL two_byte_latency got=%0d exp=5", lat); end
    total++; if ({opcode, operand} !== 16'h8A3C) begin bad++; $display("FAIL two_byte_data got=%h exp=8a3c", {opcode, operand}); end
    total++; if (npci !== 2 || npcw !== 0) begin bad++; $display("FAIL two_byte_pc_strobes got=%0d/%0d exp=2/0", npci, npcw); end
    total++; if (pc !== 8'h22) begin bad++; $display("FAIL two_byte_pc got=%h exp=22", pc); end
  endtask

  task automatic test_jump();
    int lat, npci, npcw;
    mem[8'h30] = 8'hC0; mem[8'h31] = 8'h77; setpc(8'h30);
    run_fetch(0, 0, lat, npci, npcw);
    total++; if (lat !== 6) begin bad++; $display("FAIL jump_latency got=%0d exp=6", lat); end
    total++; if (npcw !== 1 || jbus !== 8'h77) begin bad++; $display("FAIL jump_drive got=%0d/%h exp=1/77", npcw, jbus); end
    total++; if (npci !== 2) begin bad++; $display("FAIL jump_pci got=%0d exp=2", npci); end
    total++; if (pc !== 8'h77) begin bad++; $display("FAIL jump_pc got=%h exp=77", pc); end
  endtask

  task automatic test_wait_states();
    int lat, npci, npcw;
    mem[8'h77] = 8'h12; mem[8'h78] = 8'h01;
    run_fetch(3, 0, lat, npci, npcw);
    total++; if (lat !== 6) begin bad++; $display("FAIL wait3_latency got=%0d exp=6", lat); end
    total++; if (npci !== 1) begin bad++; $display("FAIL wait3_pci got=%0d exp=1", npci); end
    total++; if (opcode !== 8'h12 || operand !== 8'h77) begin bad++; $display("FAIL wait3_data got=%h%h exp=1277", opcode, operand); end
    total++; if (pc !== 8'h78) begin bad++; $display("FAIL wait3_pc got=%h exp=78", pc); end
    run_fetch(15, 0, lat, npci, npcw);
    total++; if (lat !== 18) begin bad++; $display("FAIL wait15_latency got=%0d exp=18", lat); end
    total++; if (err !== 1'b0 || opcode !== 8'h01) begin bad++; $display("FAIL wait15_accept got=%b/%h exp=0/01", err, opcode); end
    total++; if (pc !== 8'h79) begin bad++; $display("FAIL wait15_pc got=%h exp=79", pc); end
  endtask

  task automatic test_timeout();
    int lat, npci, npcw;
    mem[8'h79] = 8'h02;
    run_fetch(16, 0, lat, npci, npcw);
    total++; if (lat !== 0) begin bad++; $display("FAIL timeout_no_done got=%0d exp=0", lat); end
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL timeout_flags got=%b%b exp=10", err, busy); end
    start = 1'b1; mem_ready = 1'b1;
    tick(); tick(); tick();
    total++; if ({err, busy, pc_r, pc_i, pc_w, mar_w, mem_rd} !== 7'b1000000) begin
      bad++; $display("FAIL timeout_sticky got=%b exp=1000000", {err, busy, pc_r, pc_i, pc_w, mar_w, mem_rd}); end
    total++; if (npci !== 0 || pc !== 8'h79) begin bad++; $display("FAIL timeout_pc got=%0d/%h exp=0/79", npci, pc); end
    start = 1'b0; mem_ready = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid();
    int lat, npci, npcw;
    mem[8'h40] = 8'h85; mem[8'h41] = 8'h99; mem[8'h42] = 8'h5A; setpc(8'h40);
    start = 1'b1; tick(); start = 1'b0;   // A1
    tick(); mem_ready = 1'b1;             // R1
    tick(); mem_ready = 1'b0;             // A2
    tick();                               // R2, memory stalled
    total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL reset_mid_in_r2 got=%b exp=1", mem_rd); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if ({pc_r, pc_i, pc_w, mar_w, mem_rd, busy, done, err, dut.drive} !== 9'b0) begin
      bad++; $display("FAIL reset_mid_outputs got=%b exp=000000000", {pc_r, pc_i, pc_w, mar_w, mem_rd, busy, done, err, dut.drive}); end
    total++; if ({opcode, operand} !== 16'h0000) begin bad++; $display("FAIL reset_mid_regs got=%h exp=0000", {opcode, operand}); end
    total++; if (pc !== 8'h41) begin bad++; $display("FAIL reset_mid_pc got=%h exp=41", pc); end
    run_fetch(0, 0, lat, npci, npcw);
    total++; if (lat !== 5 || {opcode, operand} !== 16'h995A) begin
      bad++; $display("FAIL reset_mid_refetch got=%0d/%h exp=5/995a", lat, {opcode, operand}); end
    total++; if (pc !== 8'h43) begin bad++; $display("FAIL reset_mid_refetch_pc got=%h exp=43", pc); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, d3, nd;
    logic b4, a5;
    d1 = 0; d2 = 0; d3 = 0; nd = 0; b4 = 1'b1; a5 = 1'b0;
    mem[8'h50] = 8'h03; mem[8'h51] = 8'h04; mem[8'h52] = 8'h06; setpc(8'h50);
    start = 1'b1; tick();
    for (int c = 1; c <= 11; c++) begin
      mem_ready = mem_rd;
      #1;
      if (done) begin
        nd++;
        if (nd == 1) d1 = c; else if (nd == 2) d2 = c; else d3 = c;
      end
      if (c == 4) b4 = busy;
      if (c == 5) a5 = pc_r;
      if (c == 11) start = 1'b0;
      tick();
    end
    mem_ready = 1'b0;
    total++; if (nd !== 3 || d1 !== 3 || d2 !== 7 || d3 !== 11) begin
      bad++; $display("FAIL b2b_done got=%0d:%0d,%0d,%0d exp=3:3,7,11", nd, d1, d2, d3); end
    total++; if (b4 !== 1'b0 || a5 !== 1'b1) begin bad++; $display("FAIL b2b_idle_gap got=%b%b exp=01", b4, a5); end
    total++; if (opcode !== 8'h06 || pc !== 8'h53) begin bad++; $display("FAIL b2b_end got=%h/%h exp=06/53", opcode, pc); end
  endtask

  task automatic test_busy_start();
    int nd, dc;
    logic b6, b7;
    nd = 0; dc = 0; b6 = 1'b1; b7 = 1'b1;
    mem[8'h60] = 8'h81; mem[8'h61] = 8'hEE; setpc(8'h60);
    start = 1'b1; tick();
    for (int c = 1; c <= 8; c++) begin
      start = (c >= 2 && c <= 5);
      mem_ready = mem_rd;
      #1;
      if (done) begin nd++; dc = c; end
      if (c == 6) b6 = busy;
      if (c == 7) b7 = busy;
      tick();
    end
    start = 1'b0; mem_ready = 1'b0;
    total++; if (nd !== 1 || dc !== 5) begin bad++; $display("FAIL busy_start_done got=%0d@%0d exp=1@5", nd, dc); end
    total++; if (b6 !== 1'b0 || b7 !== 1'b0) begin bad++; $display("FAIL busy_start_ignored got=%b%b exp=00", b6, b7); end
    total++; if (operand !== 8'hEE || pc !== 8'h62) begin bad++; $display("FAIL busy_start_end got=%h/%h exp=ee/62", operand, pc); end
  endtask

  task automatic test_contention();
    total++; if (viol !== 0) begin bad++; $display("FAIL bus_contention got=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_two_byte();
    test_jump();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_busy_start();
    test_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
